bus_arbiter: RTL and testbench

// - Owns the minx system bus. Shares it between the s1c88 CPU and up to NUM_MASTERS DMA-style masters (PRC, cart DMA, ...).
// - Sequences the CPU bus_request/bus_ack handshake, picks one master round-robin and drives the shared bus mux.
// - Replaces the ad-hoc bus_ack-selected muxing in the top level.

---
 rtl/bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the minx bus between the s1c88 CPU and NUM_MASTERS DMA masters, round-robin.
// Optional BUS_ARB_TIMEOUT_EN adds MAX_HOLD-cycle pre-emption of a master when others are waiting.
module bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 24,
    parameter int MAX_HOLD    = 256
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_clk_ce,
    input  logic [NUM_MASTERS-1:0]        i_m_req,
    output logic [NUM_MASTERS-1:0]        o_m_grant,
    input  logic [NUM_MASTERS*ADDR_W-1:0] i_m_addr,
    input  logic [NUM_MASTERS*8-1:0]      i_m_data,
    input  logic [NUM_MASTERS-1:0]        i_m_read,
    input  logic [NUM_MASTERS-1:0]        i_m_write,
    input  logic [NUM_MASTERS*2-1:0]      i_m_status,
    input  logic [ADDR_W-1:0]             i_cpu_addr,
    input  logic [7:0]                    i_cpu_data,
    input  logic                          i_cpu_read,
    input  logic                          i_cpu_write,
    input  logic [1:0]                    i_cpu_status,
    output logic                          o_cpu_bus_request,
    input  logic                          i_cpu_bus_ack,
    output logic [ADDR_W-1:0]             o_bus_addr,
    output logic [7:0]                    o_bus_data,
    output logic                          o_bus_read,
    output logic                          o_bus_write,
    output logic [1:0]                    o_bus_status,
    output logic [2:0]                    o_owner,
    output logic                          o_preempt
);
    typedef enum logic [2:0] {IDLE, REQ, GRANT, HANDOVER, RELEASE} state_t;
    state_t                 r_state, w_state_nx;
    logic [NUM_MASTERS-1:0] r_grant, w_grant_nx, w_cur, w_pick_oh;
    logic                   r_req, w_req_nx, r_preempt, w_preempt_nx, w_any, w_take;
    logic [2:0]             r_owner, w_owner_nx, w_idx;
    logic [1:0]             r_rr, w_rr_nx, r_win, w_win_nx, w_pick;
    logic [3:0]             w_req4;
`ifdef BUS_ARB_TIMEOUT_EN
    logic [8:0]             r_hold, w_hold_nx;
`endif

    assign w_req4    = 4'(i_m_req);
    assign w_any     = |i_m_req;
    assign w_cur     = NUM_MASTERS'(1) << r_win;
    assign w_pick_oh = NUM_MASTERS'(1) << w_pick;

    // Descending scan so the lowest offset from rr_ptr wins.
    always_comb begin
        w_pick = '0;
        w_idx  = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr} + 3'(k);
            if (w_idx >= 3'(NUM_MASTERS)) w_idx = w_idx - 3'(NUM_MASTERS);
            if (w_req4[w_idx[1:0]]) w_pick = w_idx[1:0];
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_grant_nx   = r_grant;
        w_req_nx     = r_req;
        w_owner_nx   = r_owner;
        w_rr_nx      = r_rr;
        w_win_nx     = r_win;
        w_preempt_nx = 1'b0;
        w_take       = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
        w_hold_nx    = r_hold;
`endif
        case (r_state)
            IDLE: if (w_any) begin
                w_state_nx = REQ;
                w_req_nx   = 1'b1;
            end
            REQ: if (!w_any) begin
                w_state_nx = IDLE;
                w_req_nx   = 1'b0;
            end else if (i_cpu_bus_ack) w_take = 1'b1;
            GRANT: if (!i_cpu_bus_ack) begin
                w_state_nx = IDLE;
                w_grant_nx = '0;
                w_req_nx   = 1'b0;
                w_owner_nx = '0;
            end else if (!w_req4[r_win]) begin
                w_state_nx = HANDOVER;
                w_grant_nx = '0;
                w_owner_nx = '0;
            end
`ifdef BUS_ARB_TIMEOUT_EN
            else if (r_hold == 9'(MAX_HOLD) && |(i_m_req & ~w_cur)) begin
                w_state_nx   = HANDOVER;
                w_grant_nx   = '0;
                w_owner_nx   = '0;
                w_preempt_nx = 1'b1;
            end else if (r_hold != 9'(MAX_HOLD)) w_hold_nx = r_hold + 9'd1;
`endif
            HANDOVER: if (w_any) w_take = 1'b1;
            else begin
                w_state_nx = RELEASE;
                w_req_nx   = 1'b0;
            end
            RELEASE: if (!i_cpu_bus_ack) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
        if (w_take) begin
            w_state_nx = GRANT;
            w_grant_nx = w_pick_oh;
            w_owner_nx = {1'b0, w_pick} + 3'd1;
            w_win_nx   = w_pick;
            w_rr_nx    = (w_pick == 2'(NUM_MASTERS - 1)) ? 2'd0 : w_pick + 2'd1;
`ifdef BUS_ARB_TIMEOUT_EN
            w_hold_nx  = '0;
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_req     <= 1'b0;
            r_owner   <= '0;
            r_rr      <= '0;
            r_win     <= '0;
            r_preempt <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            r_hold    <= '0;
`endif
        end else if (i_clk_ce) begin
            r_state   <= w_state_nx;
            r_grant   <= w_grant_nx;
            r_req     <= w_req_nx;
            r_owner   <= w_owner_nx;
            r_rr      <= w_rr_nx;
            r_win     <= w_win_nx;
            r_preempt <= w_preempt_nx;
`ifdef BUS_ARB_TIMEOUT_EN
            r_hold    <= w_hold_nx;
`endif
        end
    end

    always_comb begin
        o_bus_addr   = i_cpu_addr;
        o_bus_data   = i_cpu_data;
        o_bus_read   = (r_state == HANDOVER) ? 1'b0 : i_cpu_read;
        o_bus_write  = (r_state == HANDOVER) ? 1'b0 : i_cpu_write;
        o_bus_status = i_cpu_status;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_state == GRANT && 2'(i) == r_win) begin
                o_bus_addr   = i_m_addr[i*ADDR_W +: ADDR_W];
                o_bus_data   = i_m_data[i*8 +: 8];
                o_bus_read   = i_m_read[i];
                o_bus_write  = i_m_write[i];
                o_bus_status = i_m_status[i*2 +: 2];
            end
        end
    end

    // Gating by ack keeps a grant from ever overlapping a CPU that has taken the bus back.
    assign o_m_grant         = r_grant & {NUM_MASTERS{i_cpu_bus_ack}};
    assign o_cpu_bus_request = r_req;
    assign o_owner           = r_owner;
    assign o_preempt         = r_preempt;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed test of bus_arbiter handshake, round-robin, abort, protocol error, async reset.
// Build with BUS_ARB_TIMEOUT_EN to exercise pre-emption at MAX_HOLD=8.
module tb_bus_arbiter;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam int MH = 8;
`else
    localparam int MH = 256;
`endif
    logic        clk = 1'b0, rst_n = 1'b0, ce = 1'b1;
    logic [1:0]  m_req = '0, m_grant, m_read = 2'b01, m_write = 2'b10;
    logic [47:0] m_addr = {24'hBBBBBB, 24'hAAAAAA};
    logic [15:0] m_data = {8'h22, 8'h11};
    logic [3:0]  m_status = {2'b11, 2'b01};
    logic [23:0] cpu_addr = 24'h123456, bus_addr;
    logic [7:0]  cpu_data = 8'hC5, bus_data;
    logic        cpu_read = 1'b1, cpu_write = 1'b0, bus_read, bus_write;
    logic [1:0]  cpu_status = 2'b10, bus_status;
    logic        cpu_req, cpu_ack = 1'b0, preempt;
    logic [2:0]  owner;
    int          n_checks = 0, n_errors = 0;

    bus_arbiter #(.NUM_MASTERS(2), .ADDR_W(24), .MAX_HOLD(MH)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_clk_ce(ce),
        .i_m_req(m_req), .o_m_grant(m_grant), .i_m_addr(m_addr), .i_m_data(m_data),
        .i_m_read(m_read), .i_m_write(m_write), .i_m_status(m_status),
        .i_cpu_addr(cpu_addr), .i_cpu_data(cpu_data), .i_cpu_read(cpu_read),
        .i_cpu_write(cpu_write), .i_cpu_status(cpu_status),
        .o_cpu_bus_request(cpu_req), .i_cpu_bus_ack(cpu_ack),
        .o_bus_addr(bus_addr), .o_bus_data(bus_data), .o_bus_read(bus_read),
        .o_bus_write(bus_write), .o_bus_status(bus_status),
        .o_owner(owner), .o_preempt(preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        m_req   = '0;
        cpu_ack = 1'b0;
        rst_n   = 1'b0;
        #2;
        rst_n   = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_grant", m_grant, 0);
        check("rst_req", cpu_req, 0);
        check("rst_owner", owner, 0);
        check("rst_preempt", preempt, 0);
        check("rst_bus_addr", bus_addr, 24'h123456);
        check("rst_bus_read", bus_read, 1);
        rst_n = 1'b1;
        tick();
        ce = 1'b0;
        m_req = 2'b01;
        tick();
        check("ce_hold_req", cpu_req, 0);
        ce = 1'b1;
        tick();
        check("single_req", cpu_req, 1);
        check("single_nogrant", m_grant, 0);
        tick();
        tick();
        cpu_ack = 1'b1;
        tick();
        check("single_grant", m_grant, 2'b01);
        check("single_owner", owner, 1);
        check("single_addr", bus_addr, 24'hAAAAAA);
        check("single_data", bus_data, 8'h11);
        check("single_rd", bus_read, 1);
        check("single_wr", bus_write, 0);
        check("single_st", bus_status, 2'b01);
        m_req = 2'b00;
        tick();
        check("ho_grant", m_grant, 0);
        check("ho_owner", owner, 0);
        check("ho_rd", bus_read, 0);
        check("ho_addr", bus_addr, 24'h123456);
        check("ho_st", bus_status, 2'b10);
        check("ho_req", cpu_req, 1);
        tick();
        check("rel_req", cpu_req, 0);
        cpu_ack = 1'b0;
        tick();
        check("idle_req", cpu_req, 0);
        check("idle_rd", bus_read, 1);

        do_reset();
        m_req = 2'b11;
        tick();
        cpu_ack = 1'b1;
        tick();
        check("rr1_grant", m_grant, 2'b01);
        for (int i = 0; i < 3; i++) tick();
        m_req = 2'b10;
        tick();
        check("rr1_ho_req", cpu_req, 1);
        m_req = 2'b11;
        tick();
        check("rr2_grant", m_grant, 2'b10);
        check("rr2_owner", owner, 2);
        check("rr2_addr", bus_addr, 24'hBBBBBB);
        check("rr2_wr", bus_write, 1);
        check("rr2_st", bus_status, 2'b11);
        for (int i = 0; i < 3; i++) tick();
        m_req = 2'b01;
        tick();
        check("rr2_ho_req", cpu_req, 1);
        m_req = 2'b11;
        tick();
        check("rr3_grant", m_grant, 2'b01);
`ifndef BUS_ARB_TIMEOUT_EN
        for (int i = 0; i < 12; i++) begin
            tick();
            check("nto_grant", m_grant, 2'b01);
            check("nto_preempt", preempt, 0);
        end
`endif
        cpu_ack = 1'b0;
        #1;
        check("perr_comb_grant", m_grant, 0);
        m_req = 2'b00;
        tick();
        check("perr_grant", m_grant, 0);
        check("perr_owner", owner, 0);
        check("perr_req", cpu_req, 0);
        check("perr_addr", bus_addr, 24'h123456);
        check("perr_rd", bus_read, 1);

        do_reset();
        m_req = 2'b01;
        tick();
        check("abort_req1", cpu_req, 1);
        m_req = 2'b00;
        tick();
        check("abort_req0", cpu_req, 0);
        cpu_ack = 1'b1;
        tick();
        check("abort_grant", m_grant, 0);

        do_reset();
        m_req = 2'b01;
        tick();
        cpu_ack = 1'b1;
        tick();
        check("ar_grant_pre", m_grant, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_grant", m_grant, 0);
        check("ar_req", cpu_req, 0);
        check("ar_owner", owner, 0);
        rst_n = 1'b1;

`ifdef BUS_ARB_TIMEOUT_EN
        do_reset();
        m_req = 2'b01;
        cpu_ack = 1'b1;
        tick();
        tick();
        check("to_grant0", m_grant, 2'b01);
        m_req = 2'b11;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("to_hold_grant", m_grant, 2'b01);
            check("to_hold_pre", preempt, 0);
        end
        tick();
        check("to_preempt", preempt, 1);
        check("to_drop", m_grant, 0);
        tick();
        check("to_pre_pulse", preempt, 0);
        check("to_grant1", m_grant, 2'b10);
        m_req = 2'b01;
        tick();
        tick();
        check("to_back0", m_grant, 2'b01);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("to_alone_grant", m_grant, 2'b01);
            check("to_alone_pre", preempt, 0);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
